ov7670_capture_ctrl: RTL and testbench

Parametrised OV7670 pixel-capture controller. It is clocked by the camera pixel clock and turns the VSYNC/HREF/D[7:0] byte stream into coordinate-tagged 16-bit pixels for the frame-buffer RAM writer. It extends the existing capture path with:
- RGB565 and YUV422-luma modes
- power-of-two decimation
- programmable frame skipping
- frame counting
- line-length error detection

---
 rtl/ov7670_capture_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_ov7670_capture_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_capture_ctrl.sv
// OV7670 pixel-capture controller: turns the VSYNC/HREF/D byte stream into
// coordinate-tagged 16-bit pixels, with decimation, frame skipping and line checks.
module ov7670_capture_ctrl #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int X_W        = 10,
    parameter int Y_W        = 9,
    parameter int DECIM_LOG2 = 0,
    parameter int SKIP_W     = 4,
    parameter int FCNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              mode,
    input  logic [SKIP_W-1:0] skip,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    output logic [X_W-1:0]    pixel_x,
    output logic [Y_W-1:0]    pixel_y,
    output logic [15:0]       pixel_data,
    output logic              pixel_valid,
    output logic              frame_start,
    output logic              frame_done,
    output logic              line_err,
    output logic [FCNT_W-1:0] frame_count
);

    // Raw counters get one spare bit beyond the decimated range so that
    // overlong lines/frames saturate clear of the active window.
    localparam int RX_W = X_W + DECIM_LOG2 + 1;
    localparam int RY_W = Y_W + DECIM_LOG2 + 1;

    localparam logic [RX_W-1:0] H_LIM  = RX_W'(H_ACTIVE);
    localparam logic [RY_W-1:0] V_LIM  = RY_W'(V_ACTIVE);
    localparam logic [RX_W-1:0] RX_MAX = '1;
    localparam logic [RY_W-1:0] RY_MAX = '1;
    localparam logic [RX_W-1:0] XMASK  = RX_W'((1 << DECIM_LOG2) - 1);
    localparam logic [RY_W-1:0] YMASK  = RY_W'((1 << DECIM_LOG2) - 1);

    typedef enum logic [1:0] {
        SYNC,
        VBLANK,
        CAPTURE,
        DROP
    } state_t;

    state_t            state_q, state_d;
    logic              vsyncDly_q;
    logic              hrefDly_q;
    logic [SKIP_W-1:0] skipCnt_q, skipCnt_d;
    logic              modeLat_q, modeLat_d;
    logic              phase_q, phase_d;
    logic [RX_W-1:0]   rx_q, rx_d;
    logic [RY_W-1:0]   ry_q, ry_d;
    logic [7:0]        byte0_q, byte0_d;
    logic              firstPend_q, firstPend_d;
    logic              pixValid_q, pixValid_d;
    logic [15:0]       pixData_q, pixData_d;
    logic [X_W-1:0]    pixX_q, pixX_d;
    logic [Y_W-1:0]    pixY_q, pixY_d;
    logic              frameStart_q, frameStart_d;
    logic              frameDone_q, frameDone_d;
    logic              lineErr_q, lineErr_d;
    logic [FCNT_W-1:0] frameCount_q, frameCount_d;

    logic vsyncFall;
    logic hrefFall;
    logic inWindow;

    assign vsyncFall = vsyncDly_q & ~vsync;
    assign hrefFall  = hrefDly_q & ~href;
    assign inWindow  = (rx_q < H_LIM) && (ry_q < V_LIM) &&
                       ((rx_q & XMASK) == '0) && ((ry_q & YMASK) == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SYNC;
            vsyncDly_q   <= 1'b0;
            hrefDly_q    <= 1'b0;
            skipCnt_q    <= '0;
            modeLat_q    <= 1'b0;
            phase_q      <= 1'b0;
            rx_q         <= '0;
            ry_q         <= '0;
            byte0_q      <= '0;
            firstPend_q  <= 1'b0;
            pixValid_q   <= 1'b0;
            pixData_q    <= '0;
            pixX_q       <= '0;
            pixY_q       <= '0;
            frameStart_q <= 1'b0;
            frameDone_q  <= 1'b0;
            lineErr_q    <= 1'b0;
            frameCount_q <= '0;
        end else begin
            state_q      <= state_d;
            vsyncDly_q   <= vsync;
            hrefDly_q    <= href;
            skipCnt_q    <= skipCnt_d;
            modeLat_q    <= modeLat_d;
            phase_q      <= phase_d;
            rx_q         <= rx_d;
            ry_q         <= ry_d;
            byte0_q      <= byte0_d;
            firstPend_q  <= firstPend_d;
            pixValid_q   <= pixValid_d;
            pixData_q    <= pixData_d;
            pixX_q       <= pixX_d;
            pixY_q       <= pixY_d;
            frameStart_q <= frameStart_d;
            frameDone_q  <= frameDone_d;
            lineErr_q    <= lineErr_d;
            frameCount_q <= frameCount_d;
        end
    end

    // Frame-level sequencing: the capture/drop decision is made once per
    // frame at the vsync fall, so enable and mode changes wait for the next frame.
    always_comb begin
        state_d      = state_q;
        skipCnt_d    = skipCnt_q;
        modeLat_d    = modeLat_q;
        frameDone_d  = 1'b0;
        frameCount_d = frameCount_q;
        case (state_q)
            SYNC: begin
                if (vsync) state_d = VBLANK;
            end
            VBLANK: begin
                if (vsyncFall) begin
                    modeLat_d = mode;
                    if (enable && (skipCnt_q == '0)) begin
                        state_d   = CAPTURE;
                        skipCnt_d = skip;
                    end else begin
                        state_d = DROP;
                        if (skipCnt_q != '0) skipCnt_d = skipCnt_q - SKIP_W'(1);
                    end
                end
            end
            CAPTURE: begin
                if (vsync) begin
                    frameDone_d  = 1'b1;
                    frameCount_d = frameCount_q + FCNT_W'(1);
                    state_d      = VBLANK;
                end
            end
            DROP: begin
                if (vsync) state_d = VBLANK;
            end
            default: state_d = SYNC;
        endcase
    end

    always_comb begin
        phase_d      = phase_q;
        rx_d         = rx_q;
        ry_d         = ry_q;
        byte0_d      = byte0_q;
        firstPend_d  = firstPend_q;
        pixValid_d   = 1'b0;
        pixData_d    = pixData_q;
        pixX_d       = pixX_q;
        pixY_d       = pixY_q;
        frameStart_d = 1'b0;
        lineErr_d    = lineErr_q;
        if (vsyncFall) begin
            phase_d     = 1'b0;
            rx_d        = '0;
            ry_d        = '0;
            firstPend_d = 1'b1;
        end else if (href) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                byte0_d = d;
            end else begin
                if (rx_q != RX_MAX) rx_d = rx_q + RX_W'(1);
                if ((state_q == CAPTURE) && inWindow) begin
                    pixValid_d = 1'b1;
                    pixData_d  = modeLat_q ? {8'h00, byte0_q} : {byte0_q, d};
                    pixX_d     = X_W'(rx_q >> DECIM_LOG2);
                    pixY_d     = Y_W'(ry_q >> DECIM_LOG2);
                    if (firstPend_q) begin
                        frameStart_d = 1'b1;
                        firstPend_d  = 1'b0;
                    end
                end
            end
        end else begin
            phase_d = 1'b0;
            // phase_q still holds the parity of the line just ended here.
            if (hrefFall) begin
                rx_d = '0;
                if (ry_q != RY_MAX) ry_d = ry_q + RY_W'(1);
                if ((state_q == CAPTURE) && (ry_q < V_LIM) && ((rx_q != H_LIM) || phase_q))
                    lineErr_d = 1'b1;
            end
        end
    end

    assign pixel_x     = pixX_q;
    assign pixel_y     = pixY_q;
    assign pixel_data  = pixData_q;
    assign pixel_valid = pixValid_q;
    assign frame_start = frameStart_q;
    assign frame_done  = frameDone_q;
    assign line_err    = lineErr_q;
    assign frame_count = frameCount_q;

endmodule

// File: tb/tb_ov7670_capture_ctrl.sv
// Directed bench for ov7670_capture_ctrl: a 4x2 full-rate instance and an
// 8x4 instance decimated by 2 share one camera stimulus stream.
module tb_ov7670_capture_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] skip = '0;
    logic       vsync = 1'b0;
    logic       href = 1'b0;
    logic [7:0] d = '0;

    logic [9:0]  aX, bX;
    logic [8:0]  aY, bY;
    logic [15:0] aData, bData;
    logic        aValid, bValid, aStart, bStart, aDone, bDone, aErr, bErr;
    logic [15:0] aCount, bCount;

    always #5 clk = ~clk;

    ov7670_capture_ctrl #(.H_ACTIVE(4), .V_ACTIVE(2), .DECIM_LOG2(0)) dutA (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .skip(skip),
        .vsync(vsync), .href(href), .d(d),
        .pixel_x(aX), .pixel_y(aY), .pixel_data(aData), .pixel_valid(aValid),
        .frame_start(aStart), .frame_done(aDone), .line_err(aErr), .frame_count(aCount)
    );

    ov7670_capture_ctrl #(.H_ACTIVE(8), .V_ACTIVE(4), .DECIM_LOG2(1)) dutB (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .skip(skip),
        .vsync(vsync), .href(href), .d(d),
        .pixel_x(bX), .pixel_y(bY), .pixel_data(bData), .pixel_valid(bValid),
        .frame_start(bStart), .frame_done(bDone), .line_err(bErr), .frame_count(bCount)
    );

    bit [15:0] qAd[$], qBd[$];
    bit [9:0]  qAx[$], qBx[$];
    bit [8:0]  qAy[$], qBy[$];
    int startA = 0, doneA = 0, misA = 0;

    always @(negedge clk) begin
        if (aValid) begin
            qAd.push_back(aData); qAx.push_back(aX); qAy.push_back(aY);
        end
        if (bValid) begin
            qBd.push_back(bData); qBx.push_back(bX); qBy.push_back(bY);
        end
        if (aStart) startA++;
        if (aStart && !aValid) misA++;
        if (aDone) doneA++;
    end

    int assertCount = 0;
    int failCount = 0;
    int byteVal = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyReset();
        reset = 1'b1; href = 1'b0; vsync = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic vsyncPulse();
        vsync = 1'b1;
        tick(3);
        vsync = 1'b0;
        tick(3);
        byteVal = 0;
    endtask

    task automatic sendLine(input int nBytes);
        for (int i = 0; i < nBytes; i++) begin
            d = 8'(byteVal);
            byteVal++;
            href = 1'b1;
            tick(1);
        end
        href = 1'b0;
        tick(2);
    endtask

    task automatic applyStimulus(input int nLines, input int bytesPerLine);
        vsyncPulse();
        for (int l = 0; l < nLines; l++) sendLine(bytesPerLine);
    endtask

    task automatic finishFrame();
        vsync = 1'b1;
        tick(3);
    endtask

    int base, baseB, dBase, sBase, pBase, yy, xx, b0;

    initial begin
        // RGB565 on a 4x2 frame
        applyReset();
        checkOutput("reset frame_count", 32'(aCount), 0);
        checkOutput("reset line_err", 32'(aErr), 0);
        checkOutput("reset pixel_data", 32'(aData), 0);
        checkOutput("reset pixel_valid", 32'(aValid), 0);
        enable = 1'b1; skip = '0; mode = 1'b0;
        base = qAd.size(); sBase = startA; dBase = doneA;
        applyStimulus(2, 8);
        finishFrame();
        @(negedge clk);
        checkOutput("rgb pixel count", 32'(qAd.size() - base), 8);
        checkOutput("rgb first data", 32'(qAd[base]), 32'h0001);
        checkOutput("rgb first x", 32'(qAx[base]), 0);
        checkOutput("rgb first y", 32'(qAy[base]), 0);
        checkOutput("rgb last data", 32'(qAd[base+7]), 32'h0E0F);
        checkOutput("rgb last x", 32'(qAx[base+7]), 3);
        checkOutput("rgb last y", 32'(qAy[base+7]), 1);
        checkOutput("rgb frame_start count", 32'(startA - sBase), 1);
        checkOutput("rgb frame_start aligned", 32'(misA), 0);
        checkOutput("rgb frame_done count", 32'(doneA - dBase), 1);
        checkOutput("rgb frame_count", 32'(aCount), 1);
        checkOutput("rgb line_err", 32'(aErr), 0);

        // YUV422 luma from the same stream
        mode = 1'b1;
        base = qAd.size();
        applyStimulus(2, 8);
        mode = 1'b0;
        finishFrame();
        @(negedge clk);
        checkOutput("yuv pixel count", 32'(qAd.size() - base), 8);
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("yuv data %0d", i), 32'(qAd[base+i]), 32'(2*i));
        checkOutput("yuv frame_count", 32'(aCount), 2);

        // Decimation by 2 on an 8x4 frame
        applyReset();
        baseB = qBd.size();
        applyStimulus(4, 16);
        finishFrame();
        @(negedge clk);
        checkOutput("decim pixel count", 32'(qBd.size() - baseB), 8);
        for (int i = 0; i < 8; i++) begin
            yy = i / 4; xx = i % 4; b0 = 32*yy + 4*xx;
            checkOutput($sformatf("decim data %0d", i), 32'(qBd[baseB+i]), 32'((b0 << 8) | (b0 + 1)));
            checkOutput($sformatf("decim x %0d", i), 32'(qBx[baseB+i]), 32'(xx));
            checkOutput($sformatf("decim y %0d", i), 32'(qBy[baseB+i]), 32'(yy));
        end
        checkOutput("decim line_err", 32'(bErr), 0);
        checkOutput("decim frame_count", 32'(bCount), 1);

        // Skip 2 over 6 frames: frames 1 and 4 captured
        applyReset();
        skip = 4'd2;
        base = qAd.size();
        applyStimulus(2, 8);
        checkOutput("skip after f1", 32'(qAd.size() - base), 8);
        applyStimulus(2, 8);
        applyStimulus(2, 8);
        checkOutput("skip after f3", 32'(qAd.size() - base), 8);
        applyStimulus(2, 8);
        checkOutput("skip after f4", 32'(qAd.size() - base), 16);
        applyStimulus(2, 8);
        applyStimulus(2, 8);
        finishFrame();
        @(negedge clk);
        checkOutput("skip pixel total", 32'(qAd.size() - base), 16);
        checkOutput("skip frame_count", 32'(aCount), 2);
        skip = '0;

        // Enable low for a full run
        applyReset();
        enable = 1'b0;
        base = qAd.size();
        for (int f = 0; f < 3; f++) applyStimulus(2, 8);
        finishFrame();
        @(negedge clk);
        checkOutput("disabled pixels", 32'(qAd.size() - base), 0);
        checkOutput("disabled frame_count", 32'(aCount), 0);
        enable = 1'b1;

        // Short line sets a sticky line_err
        applyReset();
        vsyncPulse();
        sendLine(8);
        @(negedge clk);
        checkOutput("err before short line", 32'(aErr), 0);
        sendLine(6);
        @(negedge clk);
        checkOutput("err after short line", 32'(aErr), 1);
        applyStimulus(2, 8);
        finishFrame();
        @(negedge clk);
        checkOutput("err sticky", 32'(aErr), 1);
        applyReset();
        checkOutput("err cleared by reset", 32'(aErr), 0);
        vsyncPulse();
        sendLine(9);
        @(negedge clk);
        checkOutput("err odd bytes", 32'(aErr), 1);

        // Reset in the middle of a line
        applyReset();
        applyStimulus(2, 8);
        vsyncPulse();
        checkOutput("pre-abort frame_count", 32'(aCount), 1);
        for (int i = 0; i < 3; i++) begin
            d = 8'(byteVal); byteVal++; href = 1'b1; tick(1);
        end
        reset = 1'b1; href = 1'b0;
        tick(1);
        checkOutput("abort frame_count", 32'(aCount), 0);
        checkOutput("abort pixel_data", 32'(aData), 0);
        checkOutput("abort pixel_valid", 32'(aValid), 0);
        checkOutput("abort line_err", 32'(aErr), 0);
        checkOutput("abort frame_done", 32'(aDone), 0);
        reset = 1'b0;
        tick(2);
        dBase = doneA; base = qAd.size();
        applyStimulus(2, 8);
        finishFrame();
        @(negedge clk);
        checkOutput("post-abort frame_done", 32'(doneA - dBase), 1);
        checkOutput("post-abort frame_count", 32'(aCount), 1);
        checkOutput("post-abort pixels", 32'(qAd.size() - base), 8);
        checkOutput("post-abort last data", 32'(qAd[qAd.size()-1]), 32'h0E0F);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
